// File: rtl/fpu_result_collector.sv
// In-order result FIFO between the FPU output port and register-file writeback,
// with sticky exception flags accumulated as results retire.
module fpu_result_collector #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         fpu_result_i,
  input  logic [4:0]               fpu_status_i,
  input  logic [TAG_W-1:0]         fpu_tag_i,
  input  logic                     fpu_valid_i,
  output logic                     fpu_ready_o,
  output logic [WIDTH-1:0]         wb_data_o,
  output logic [4:0]               wb_status_o,
  output logic [TAG_W-1:0]         wb_tag_o,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  input  logic                     flush_i,
  input  logic                     fflags_clr_i,
  output logic [4:0]               fflags_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] data_mem   [DEPTH];
  logic [4:0]       status_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem    [DEPTH];

  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [4:0]    fflags_q;
  logic          enq, deq;

  assign fpu_ready_o = (cnt != FULL_CNT) & ~rst_i;
  assign wb_valid_o  = (cnt != '0);
  assign enq         = fpu_valid_i & fpu_ready_o;
  assign deq         = wb_valid_o & wb_ready_i;

  assign wb_data_o   = data_mem[rp];
  assign wb_status_o = status_mem[rp];
  assign wb_tag_o    = tag_mem[rp];
  assign fflags_o    = fflags_q;
  assign count_o     = cnt;

  // Storage is intentionally not reset; enq is already blocked while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (enq && !flush_i) begin
      data_mem[wp]   <= fpu_result_i;
      status_mem[wp] <= fpu_status_i;
      tag_mem[wp]    <= fpu_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      fflags_q <= '0;
    end else begin
      // A dequeue during flush still retires, so its status is kept.
      fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | (deq ? wb_status_o : 5'b0);
      if (flush_i) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (enq) wp <= wp + 1'b1;
        if (deq) rp <= rp + 1'b1;
        case ({enq, deq})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Bench for fpu_result_collector: per-cycle vector table with hand-derived
// occupancy/flag expectations, plus a scoreboard queue checking retired entries.
module tb_fpu_result_collector;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic [3:0]  fpu_tag_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_status_o;
  logic [3:0]  wb_tag_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic        flush_i;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;
  logic [2:0]  count_o;

  fpu_result_collector #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .wb_data_o(wb_data_o), .wb_status_o(wb_status_o), .wb_tag_o(wb_tag_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .flush_i(flush_i), .fflags_clr_i(fflags_clr_i),
    .fflags_o(fflags_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] d;
    logic [4:0]  st;
    logic [3:0]  tg;
    bit          wr;
    bit          fl;
    bit          clr;
    int          ecnt;
    logic [4:0]  eff;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  st;
    logic [3:0]  tg;
  } ent_t;

  ent_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   step_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit v, logic [31:0] d, logic [4:0] st, logic [3:0] tg,
                              bit wr, bit fl, bit clr, int ecnt, logic [4:0] eff);
    vec_t r;
    r.v = v; r.d = d; r.st = st; r.tg = tg; r.wr = wr; r.fl = fl; r.clr = clr;
    r.ecnt = ecnt; r.eff = eff;
    return r;
  endfunction

  // Drives one cycle; called just after a rising edge.
  task automatic step(input vec_t s);
    bit   m_rdy, m_deq, m_enq;
    ent_t e;
    step_no++;
    fpu_valid_i  = s.v;
    fpu_result_i = s.d;
    fpu_status_i = s.st;
    fpu_tag_i    = s.tg;
    wb_ready_i   = s.wr;
    flush_i      = s.fl;
    fflags_clr_i = s.clr;
    @(negedge clk);
    m_rdy = (sb.size() < 4) && !rst_i;
    chk("fpu_ready", {31'b0, fpu_ready_o}, {31'b0, m_rdy});
    m_deq = (sb.size() != 0) && s.wr;
    if (m_deq) begin
      chk("wb_data", wb_data_o, sb[0].d);
      chk("wb_tag", {28'b0, wb_tag_o}, {28'b0, sb[0].tg});
      chk("wb_status", {27'b0, wb_status_o}, {27'b0, sb[0].st});
      void'(sb.pop_front());
    end
    m_enq = s.v && m_rdy;
    if (s.fl) sb.delete();
    else if (m_enq) begin
      e.d = s.d; e.st = s.st; e.tg = s.tg;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    chk("count", {29'b0, count_o}, s.ecnt);
    chk("wb_valid", {31'b0, wb_valid_o}, {31'b0, (s.ecnt != 0)});
    chk("fflags", {27'b0, fflags_o}, {27'b0, s.eff});
  endtask

  vec_t tbl[13];

  initial begin
    // latency
    tbl[0]  = mk(1, 32'h40C00000, 5'b00000, 4'd3, 1, 0, 0, 1, 5'b00000);
    tbl[1]  = mk(0, 32'h0,        5'b00000, 4'd0, 1, 0, 0, 0, 5'b00000);
    // sticky flags, clear together with a retire
    tbl[2]  = mk(1, 32'h7FC00000, 5'b10000, 4'd1, 0, 0, 0, 1, 5'b00000);
    tbl[3]  = mk(1, 32'h3F800000, 5'b00001, 4'd2, 1, 0, 0, 1, 5'b10000);
    tbl[4]  = mk(1, 32'h40000000, 5'b00100, 4'd5, 1, 0, 0, 1, 5'b10001);
    tbl[5]  = mk(0, 32'h0,        5'b00000, 4'd0, 1, 0, 1, 0, 5'b00100);
    // flush with three DZ entries and a concurrent enqueue
    tbl[6]  = mk(1, 32'h11111111, 5'b01000, 4'd6, 0, 0, 0, 1, 5'b00100);
    tbl[7]  = mk(1, 32'h22222222, 5'b01000, 4'd7, 0, 0, 0, 2, 5'b00100);
    tbl[8]  = mk(1, 32'h33333333, 5'b01000, 4'd8, 0, 0, 0, 3, 5'b00100);
    tbl[9]  = mk(1, 32'hDEADBEEF, 5'b00010, 4'd9, 0, 1, 0, 0, 5'b00100);
    tbl[10] = mk(0, 32'h0,        5'b00000, 4'd0, 1, 0, 0, 0, 5'b00100);
    // flush with a completing dequeue keeps its status
    tbl[11] = mk(1, 32'h44444444, 5'b00010, 4'hA, 0, 0, 0, 1, 5'b00100);
    tbl[12] = mk(0, 32'h0,        5'b00000, 4'd0, 1, 1, 0, 0, 5'b00110);

    rst_i = 1'b1; fpu_valid_i = 0; fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
    wb_ready_i = 0; flush_i = 0; fflags_clr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {29'b0, count_o}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
    chk("rst_fflags", {27'b0, fflags_o}, 32'd0);
    chk("rst_ready_held", {31'b0, fpu_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rst_ready_released", {31'b0, fpu_ready_o}, 32'd1);

    for (int i = 0; i < 13; i++) step(tbl[i]);

    // backpressure: fifth result waits for the first dequeue
    for (int i = 0; i < 4; i++)
      step(mk(1, 32'hA0000000 + i, 5'b0, 4'(i), 0, 0, 0, i + 1, 5'b00110));
    step(mk(1, 32'hA0000004, 5'b0, 4'd4, 0, 0, 0, 4, 5'b00110));
    chk("full_ready", {31'b0, fpu_ready_o}, 32'd0);
    step(mk(1, 32'hA0000004, 5'b0, 4'd4, 1, 0, 0, 3, 5'b00110));
    step(mk(1, 32'hA0000004, 5'b0, 4'd4, 1, 0, 0, 3, 5'b00110));
    for (int i = 2; i >= 0; i--)
      step(mk(0, 32'h0, 5'b0, 4'd0, 1, 0, 0, i, 5'b00110));

    // wrap-around streaming
    for (int i = 0; i < 10; i++)
      step(mk(1, 32'hC0DE0000 + 32'(i * 7), 5'b0, (i % 2 == 0) ? 4'd5 : 4'd10,
              1, 0, 0, 1, 5'b00110));
    step(mk(0, 32'h0, 5'b0, 4'd0, 1, 0, 0, 0, 5'b00110));

    // mid-operation reset with two entries and fflags = NX
    step(mk(1, 32'hB0000001, 5'b00001, 4'd1, 0, 0, 0, 1, 5'b00110));
    step(mk(1, 32'hB0000002, 5'b00000, 4'd2, 1, 0, 1, 1, 5'b00001));
    step(mk(1, 32'hB0000003, 5'b00000, 4'd3, 0, 0, 0, 2, 5'b00001));
    rst_i = 1'b1; wb_ready_i = 1'b1; fpu_valid_i = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_ready", {31'b0, fpu_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_count", {29'b0, count_o}, 32'd0);
    chk("mid_rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
    chk("mid_rst_fflags", {27'b0, fflags_o}, 32'd0);
    chk("mid_rst_ready_after", {31'b0, fpu_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_ready_hold", {31'b0, fpu_ready_o}, 32'd0);
    rst_i = 1'b0; fpu_valid_i = 1'b0;
    #1;
    chk("mid_rst_ready_release", {31'b0, fpu_ready_o}, 32'd1);
    @(posedge clk); #1;
    chk("post_rst_count", {29'b0, count_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
